// File: rtl/ptp_tx_sched.sv
// PTP transmit scheduler.
// In master mode it requests sync frames periodically. In slave mode it
// requests a delay-request frame after each received sync. It then waits for
// the TX confirmation and for the response, and counts timeouts.
module ptp_tx_sched #(
  parameter int CNT_W = 32,
  parameter int TO_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sched_en,
  input  logic             master_mode,
  input  logic [CNT_W-1:0] sync_interval,
  input  logic [CNT_W-1:0] req_delay,
  input  logic [CNT_W-1:0] resp_timeout,
  input  logic             sync_rx_valid,
  input  logic             resp_rx_valid,
  input  logic [3:0]       ptp_send_type,
  input  logic             ptp_send_type_valid,
  output logic             send_sync_pkt,
  output logic             send_dreq_pkt,
  output logic [CNT_W-1:0] sync_cnt,
  output logic [CNT_W-1:0] req_cnt,
  output logic [TO_W-1:0]  timeout_cnt,
  output logic [2:0]       sched_state
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    M_WAIT      = 3'd1,
    S_WAIT_SYNC = 3'd2,
    S_DELAY     = 3'd3,
    S_WAIT_TX   = 3'd4,
    S_WAIT_RESP = 3'd5
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_send_sync;
  logic             r_send_dreq;
  logic [CNT_W-1:0] r_sync_cnt;
  logic [CNT_W-1:0] r_req_cnt;
  logic [TO_W-1:0]  r_timeout_cnt;

  logic [CNT_W-1:0] w_eff_int;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W:0]   w_cnt_next_ext;
  logic             w_int_hit;
  logic             w_dly_hit;
  logic             w_to_hit;
  logic             w_slave_state;
  logic             w_abort;
  logic             w_tx_sync;
  logic             w_tx_dreq;

  // Statistic counters hold at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [TO_W-1:0] sat_inc_to(input logic [TO_W-1:0] v);
    return (&v) ? v : v + TO_W'(1);
  endfunction

  // A period below 2 is raised to 2, so sync pulses never land back to back.
  assign w_eff_int = (sync_interval < CNT_W'(2)) ? CNT_W'(2) : sync_interval;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_int_hit = (r_cnt >= (w_eff_int - CNT_W'(1)));
  // The ">=" compares also cover a limit that is lowered while a wait runs.
  assign w_dly_hit = (r_cnt >= req_delay);
  // The response wait expires on the edge where cnt would reach resp_timeout,
  // which is exactly resp_timeout cycles after the wait began.
  assign w_cnt_next_ext = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_to_hit       = (w_cnt_next_ext >= {1'b0, resp_timeout});

  assign w_slave_state = (r_state == S_WAIT_SYNC) || (r_state == S_DELAY) ||
                         (r_state == S_WAIT_TX)   || (r_state == S_WAIT_RESP);
  // A disable, or a mode input that no longer matches the active role, drops
  // the scheduler back to IDLE. No pulse is issued in that cycle.
  assign w_abort = (r_state != IDLE) &&
                   (!sched_en ||
                    ((r_state == M_WAIT) && !master_mode) ||
                    (w_slave_state && master_mode));

  assign w_tx_sync = ptp_send_type_valid && (ptp_send_type == 4'd1);
  assign w_tx_dreq = ptp_send_type_valid && (ptp_send_type == 4'd3);

  // Scheduler FSM: state, shared cycle counter, request pulses and exchange stats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_send_sync   <= 1'b0;
      r_send_dreq   <= 1'b0;
      r_req_cnt     <= '0;
      r_timeout_cnt <= '0;
    end else begin
      r_send_sync <= 1'b0;
      r_send_dreq <= 1'b0;
      if (w_abort) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_cnt <= '0;
            if (sched_en) begin
              r_state <= master_mode ? M_WAIT : S_WAIT_SYNC;
            end
          end
          M_WAIT: begin
            if (w_int_hit) begin
              r_send_sync <= 1'b1;
              r_cnt       <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          S_WAIT_SYNC: begin
            if (sync_rx_valid) begin
              r_cnt   <= '0;
              r_state <= S_DELAY;
            end
          end
          S_DELAY: begin
            if (w_dly_hit) begin
              r_send_dreq <= 1'b1;
              r_cnt       <= '0;
              r_state     <= S_WAIT_TX;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          S_WAIT_TX: begin
            if (w_tx_dreq) begin
              r_cnt   <= '0;
              r_state <= S_WAIT_RESP;
            end else if (w_to_hit) begin
              r_timeout_cnt <= sat_inc_to(r_timeout_cnt);
              r_cnt         <= '0;
              r_state       <= S_WAIT_SYNC;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          S_WAIT_RESP: begin
            // The awaited response takes priority over a timeout in the same cycle.
            if (resp_rx_valid) begin
              r_req_cnt <= sat_inc_cnt(r_req_cnt);
              r_cnt     <= '0;
              r_state   <= S_WAIT_SYNC;
            end else if (w_to_hit) begin
              r_timeout_cnt <= sat_inc_to(r_timeout_cnt);
              r_cnt         <= '0;
              r_state       <= S_WAIT_SYNC;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Count every confirmed sync transmission, regardless of scheduler state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_cnt <= '0;
    end else if (w_tx_sync) begin
      r_sync_cnt <= sat_inc_cnt(r_sync_cnt);
    end
  end

  assign send_sync_pkt = r_send_sync;
  assign send_dreq_pkt = r_send_dreq;
  assign sync_cnt      = r_sync_cnt;
  assign req_cnt       = r_req_cnt;
  assign timeout_cnt   = r_timeout_cnt;
  assign sched_state   = r_state;

endmodule

// File: tb/tb_ptp_tx_sched.sv
// Directed bench for ptp_tx_sched. It uses a 2-bit timeout counter so that
// saturation can be reached quickly.
module tb_ptp_tx_sched;

  localparam int CNT_W = 32;
  localparam int TO_W  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sched_en;
  logic             master_mode;
  logic [CNT_W-1:0] sync_interval;
  logic [CNT_W-1:0] req_delay;
  logic [CNT_W-1:0] resp_timeout;
  logic             sync_rx_valid;
  logic             resp_rx_valid;
  logic [3:0]       ptp_send_type;
  logic             ptp_send_type_valid;
  logic             send_sync_pkt;
  logic             send_dreq_pkt;
  logic [CNT_W-1:0] sync_cnt;
  logic [CNT_W-1:0] req_cnt;
  logic [TO_W-1:0]  timeout_cnt;
  logic [2:0]       sched_state;

  int n_chk = 0;
  int n_err = 0;

  ptp_tx_sched #(.CNT_W(CNT_W), .TO_W(TO_W)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .sched_en            (sched_en),
    .master_mode         (master_mode),
    .sync_interval       (sync_interval),
    .req_delay           (req_delay),
    .resp_timeout        (resp_timeout),
    .sync_rx_valid       (sync_rx_valid),
    .resp_rx_valid       (resp_rx_valid),
    .ptp_send_type       (ptp_send_type),
    .ptp_send_type_valid (ptp_send_type_valid),
    .send_sync_pkt       (send_sync_pkt),
    .send_dreq_pkt       (send_dreq_pkt),
    .sync_cnt            (sync_cnt),
    .req_cnt             (req_cnt),
    .timeout_cnt         (timeout_cnt),
    .sched_state         (sched_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_sync_rx();
    sync_rx_valid = 1'b1;
    tick(1);
    sync_rx_valid = 1'b0;
  endtask

  task automatic send_confirm(input logic [3:0] typ);
    ptp_send_type       = typ;
    ptp_send_type_valid = 1'b1;
    tick(1);
    ptp_send_type_valid = 1'b0;
    ptp_send_type       = 4'd0;
  endtask

  // Wait (bounded) for send_dreq_pkt; n = edges waited, -1 if it never came.
  task automatic wait_dreq(output int n);
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      tick(1);
      if (send_dreq_pkt) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=expired exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc [0:3];
    int np;
    int nd;
    logic [7:0] pat;
    logic seen;

    rst_n = 1'b0;
    sched_en = 1'b0;
    master_mode = 1'b0;
    sync_interval = '0;
    req_delay = '0;
    resp_timeout = '0;
    sync_rx_valid = 1'b0;
    resp_rx_valid = 1'b0;
    ptp_send_type = 4'd0;
    ptp_send_type_valid = 1'b0;

    tick(3);
    chk("rst_state", sched_state, 0);
    chk("rst_sync_pkt", send_sync_pkt, 0);
    chk("rst_dreq_pkt", send_dreq_pkt, 0);
    chk("rst_counts", {sync_cnt, req_cnt[29:0], timeout_cnt}, 0);
    rst_n = 1'b1;
    tick(1);
    chk("idle_disabled", sched_state, 0);

    // Master, interval 10: pulses at cycles 11, 21, 31 after enable.
    sync_interval = 10;
    master_mode = 1'b1;
    sched_en = 1'b1;
    for (int i = 0; i < 4; i++) pc[i] = -1;
    np = 0;
    for (int c = 1; c <= 31; c++) begin
      tick(1);
      if (c == 1) chk("m_state", sched_state, 1);
      if (send_sync_pkt) begin
        if (np < 4) pc[np] = c;
        np++;
      end
    end
    chk("m_npulse", np, 3);
    chk("m_pulse0", pc[0], 11);
    chk("m_pulse1", pc[1], 21);
    chk("m_pulse2", pc[2], 31);

    // Sync confirmations count; a type-3 confirmation does not.
    send_confirm(4'd1);
    send_confirm(4'd3);
    send_confirm(4'd1);
    chk("sync_cnt", sync_cnt, 2);

    // Interval 0 is treated as 2.
    sched_en = 1'b0;
    tick(1);
    chk("m_disable", sched_state, 0);
    sync_interval = 0;
    sched_en = 1'b1;
    pat = '0;
    for (int c = 1; c <= 7; c++) begin
      tick(1);
      pat[c] = send_sync_pkt;
    end
    chk("m_int0_pattern", pat, 8'b1010_1000);

    // Mode toggle in M_WAIT: IDLE with no pulse, then S_WAIT_SYNC.
    sync_interval = 10;
    req_delay = 5;
    resp_timeout = 20;
    tick(3);
    master_mode = 1'b0;
    tick(1);
    chk("toggle_idle", sched_state, 0);
    chk("toggle_nopulse", send_sync_pkt, 0);
    tick(1);
    chk("toggle_slave", sched_state, 2);

    // Slave happy path.
    pulse_sync_rx();
    chk("s_delay_state", sched_state, 3);
    wait_dreq(nd);
    chk("s_dreq_latency", nd, 6);
    chk("s_wait_tx_state", sched_state, 4);
    tick(1);
    chk("s_dreq_single", send_dreq_pkt, 0);
    send_confirm(4'd3);
    chk("s_wait_resp_state", sched_state, 5);
    resp_rx_valid = 1'b1;
    tick(1);
    resp_rx_valid = 1'b0;
    chk("s_req_cnt", req_cnt, 1);
    chk("s_back_wait_sync", sched_state, 2);
    chk("s_sync_cnt_kept", sync_cnt, 2);

    // Response timeout: exactly 20 cycles after the confirmation.
    pulse_sync_rx();
    wait_dreq(nd);
    chk("to_dreq_latency", nd, 6);
    send_confirm(4'd3);
    tick(19);
    chk("to_before_state", sched_state, 5);
    chk("to_before_cnt", timeout_cnt, 0);
    tick(1);
    chk("to_state", sched_state, 2);
    chk("to_cnt", timeout_cnt, 1);

    // Response coincides with the timeout: the response wins.
    pulse_sync_rx();
    wait_dreq(nd);
    send_confirm(4'd3);
    tick(19);
    resp_rx_valid = 1'b1;
    tick(1);
    resp_rx_valid = 1'b0;
    chk("coin_req_cnt", req_cnt, 2);
    chk("coin_to_cnt", timeout_cnt, 1);
    chk("coin_state", sched_state, 2);

    // Missing TX confirmation times out too; timeout_cnt saturates at 3.
    for (int k = 0; k < 3; k++) begin
      pulse_sync_rx();
      wait_dreq(nd);
      tick(19);
      chk("txto_pending", sched_state, 4);
      tick(1);
      chk("txto_state", sched_state, 2);
      chk("txto_cnt", timeout_cnt, (k == 0) ? 2 : 3);
    end

    // Late response outside S_WAIT_RESP is ignored.
    resp_rx_valid = 1'b1;
    tick(1);
    resp_rx_valid = 1'b0;
    chk("ignore_resp", req_cnt, 2);

    // Disable while in S_DELAY: IDLE next cycle, no delay request.
    pulse_sync_rx();
    tick(2);
    chk("dis_in_delay", sched_state, 3);
    sched_en = 1'b0;
    tick(1);
    chk("dis_state", sched_state, 0);
    seen = send_dreq_pkt;
    for (int c = 0; c < 8; c++) begin
      tick(1);
      seen = seen | send_dreq_pkt;
    end
    chk("dis_no_dreq", seen, 0);

    // Asynchronous reset while in S_WAIT_RESP.
    sched_en = 1'b1;
    tick(1);
    pulse_sync_rx();
    wait_dreq(nd);
    send_confirm(4'd3);
    chk("rst2_pre_state", sched_state, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2_state", sched_state, 0);
    chk("rst2_counts", {sync_cnt, req_cnt[29:0], timeout_cnt}, 0);
    chk("rst2_pulses", {send_sync_pkt, send_dreq_pkt}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("rst2_restart", sched_state, 2);
    chk("rst2_nopulse", {send_sync_pkt, send_dreq_pkt}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
